// File: rtl/pcs_10g_tx_sched_if.sv
// Upstream beat bus, downstream PCS pause input and PCS-side word outputs of the TX scheduler.
// master drives the beats and pcs_ready_i; slave is the scheduler.
interface pcs_10g_tx_sched_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic [KEEP_W-1:0] keep_i;
    logic              last_i;
    logic              err_i;
    logic              pcs_ready_i;
    logic              ctrl_v_o;
    logic              idle_v_o;
    logic              start_o;
    logic              last_o;
    logic              err_o;
    logic [DATA_W-1:0] data_o;
    logic [KEEP_W-1:0] keep_o;
    logic              underrun_o;

    modport master (
        output valid_i, data_i, keep_i, last_i, err_i, pcs_ready_i,
        input  ready_o, ctrl_v_o, idle_v_o, start_o, last_o, err_o, data_o, keep_o, underrun_o
    );

    modport slave (
        input  valid_i, data_i, keep_i, last_i, err_i, pcs_ready_i,
        output ready_o, ctrl_v_o, idle_v_o, start_o, last_o, err_o, data_o, keep_o, underrun_o
    );
endinterface

// File: rtl/pcs_10g_tx_sched.sv
// 10G PCS transmit scheduler: frames upstream beats into start/data/terminate words and
// inserts inter-packet idles using a deficit idle counter to hold the average IPG.
module pcs_10g_tx_sched #(
    parameter int IPG_MIN      = 12,
    parameter int XGMII_DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    pcs_10g_tx_sched_if.slave bus
);
    localparam int KEEP_W = XGMII_DATA_W / 8;

    typedef enum logic [1:0] {IDLE, DATA, IPG} state_t;

    typedef struct packed {
        logic                    ctrl;
        logic                    idle;
        logic                    start;
        logic                    last;
        logic                    err;
        logic [XGMII_DATA_W-1:0] data;
        logic [KEEP_W-1:0]       keep;
    } word_t;

    localparam word_t IDLE_WORD = '{ctrl: 1'b1, idle: 1'b1, start: 1'b0, last: 1'b0,
                                    err: 1'b0, data: {KEEP_W{8'h07}}, keep: '0};
    localparam word_t ERR_WORD  = '{ctrl: 1'b1, idle: 1'b0, start: 1'b0, last: 1'b0,
                                    err: 1'b1, data: {KEEP_W{8'hFE}}, keep: '1};

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  dic_q, dic_d;
    word_t       word_q, word_d;
    logic        underrun_q, underrun_d;

    logic [3:0]  k;
    logic        keep_zero;
    logic [6:0]  gap_sum;
    logic [6:0]  rlen;
    logic [3:0]  dic_sum;
    logic [3:0]  last_cnt;
    logic [1:0]  last_dic;

    assign bus.ready_o = bus.pcs_ready_i && (state_q != IPG);

    // Idle-word count and new deficit for a terminating beat, from its byte count.
    always_comb begin
        k = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            k = k + 4'(bus.keep_i[i]);
        end
        keep_zero = (bus.keep_i == '0);
        if (keep_zero) begin
            k = 4'd8;
        end
        gap_sum  = 7'(IPG_MIN) + 7'(k);
        rlen     = (gap_sum > 7'd8) ? gap_sum - 7'd8 : '0;
        dic_sum  = 4'(dic_q) + 4'(rlen[2:0]);
        last_cnt = rlen[6:3];
        last_dic = dic_q;
        if (rlen[2:0] != 3'd0) begin
            if (dic_sum <= 4'd3) begin
                last_dic = dic_sum[1:0];
            end else begin
                last_cnt = rlen[6:3] + 4'd1;
                last_dic = (dic_sum > 4'd8) ? 2'(dic_sum - 4'd8) : 2'd0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dic_d      = dic_q;
        word_d     = word_q;
        underrun_d = 1'b0;
        if (bus.pcs_ready_i) begin
            word_d = IDLE_WORD;
            unique case (state_q)
                IDLE, DATA: begin
                    if (bus.valid_i) begin
                        word_d.idle  = 1'b0;
                        word_d.start = (state_q == IDLE);
                        word_d.ctrl  = (state_q == IDLE) || bus.err_i;
                        word_d.err   = (state_q == DATA) && bus.err_i;
                        word_d.data  = bus.data_i;
                        word_d.keep  = '1;
                        state_d      = DATA;
                        if (bus.last_i) begin
                            word_d.ctrl = 1'b1;
                            word_d.last = 1'b1;
                            word_d.err  = keep_zero || bus.err_i;
                            word_d.keep = keep_zero ? '1 : bus.keep_i;
                            cnt_d       = last_cnt;
                            dic_d       = last_dic;
                            state_d     = (last_cnt != 4'd0) ? IPG : IDLE;
                        end
                    end else if (state_q == DATA) begin
                        word_d     = ERR_WORD;
                        underrun_d = 1'b1;
                    end
                end
                IPG: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dic_q      <= '0;
            word_q     <= IDLE_WORD;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dic_q      <= dic_d;
            word_q     <= word_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.ctrl_v_o   = word_q.ctrl;
    assign bus.idle_v_o   = word_q.idle;
    assign bus.start_o    = word_q.start;
    assign bus.last_o     = word_q.last;
    assign bus.err_o      = word_q.err;
    assign bus.data_o     = word_q.data;
    assign bus.keep_o     = word_q.keep;
    assign bus.underrun_o = underrun_q;
endmodule

// File: tb/tb_pcs_10g_tx_sched.sv
// Scoreboard bench for pcs_10g_tx_sched: a frame-level model predicts every PCS word,
// a monitor pops and compares each word the DUT emits and checks holds during pauses.
module tb_pcs_10g_tx_sched;
    localparam int IPG_MIN = 12;

    typedef struct packed {
        logic        ctrl;
        logic        idle;
        logic        start;
        logic        last;
        logic        err;
        logic        und;
        logic [63:0] data;
        logic [7:0]  keep;
    } w_t;

    localparam w_t IDLE_W = '{ctrl: 1'b1, idle: 1'b1, start: 1'b0, last: 1'b0, err: 1'b0,
                              und: 1'b0, data: 64'h0707070707070707, keep: 8'h00};
    localparam w_t UND_W  = '{ctrl: 1'b1, idle: 1'b0, start: 1'b0, last: 1'b0, err: 1'b1,
                              und: 1'b1, data: 64'hFEFEFEFEFEFEFEFE, keep: 8'hFF};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcs_10g_tx_sched_if #(.DATA_W(64)) bus ();

    pcs_10g_tx_sched #(.IPG_MIN(IPG_MIN), .XGMII_DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    w_t exp_q[$];
    w_t hold_ref = IDLE_W;

    // Frame-level reference state: inside a frame, idles still owed, deficit counter.
    bit m_in_frame = 1'b0;
    int m_ipg = 0;
    int m_dic = 0;

    function automatic w_t get_out();
        w_t w;
        w.ctrl  = bus.ctrl_v_o;
        w.idle  = bus.idle_v_o;
        w.start = bus.start_o;
        w.last  = bus.last_o;
        w.err   = bus.err_o;
        w.und   = bus.underrun_o;
        w.data  = bus.data_o;
        w.keep  = bus.keep_o;
        return w;
    endfunction

    function automatic void chk_word(input string name, input w_t got, input w_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got c/i/s/l/e/u=%b%b%b%b%b%b data=%h keep=%h, expected c/i/s/l/e/u=%b%b%b%b%b%b data=%h keep=%h",
                     name, $time, got.ctrl, got.idle, got.start, got.last, got.err, got.und, got.data, got.keep,
                     exp.ctrl, exp.idle, exp.start, exp.last, exp.err, exp.und, exp.data, exp.keep);
        end
    endfunction

    function automatic void chk_bit(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
        end
    endfunction

    function automatic w_t model_step(input bit v, input logic [63:0] d, input logic [7:0] kp,
                                      input bit l, input bit e);
        w_t w;
        w = IDLE_W;
        if (m_ipg > 0) begin
            m_ipg--;
            return w;
        end
        if (!v) begin
            if (m_in_frame) w = UND_W;
            return w;
        end
        w.idle  = 1'b0;
        w.data  = d;
        w.keep  = 8'hFF;
        w.start = !m_in_frame;
        w.ctrl  = m_in_frame ? e : 1'b1;
        w.err   = m_in_frame ? e : 1'b0;
        m_in_frame = 1'b1;
        if (l) begin
            int kk, rr, q, r, wc;
            kk = $countones(kp);
            w.ctrl = 1'b1;
            w.last = 1'b1;
            w.err  = e;
            w.keep = kp;
            if (kk == 0) begin
                kk = 8;
                w.keep = 8'hFF;
                w.err = 1'b1;
            end
            rr = IPG_MIN - (8 - kk);
            if (rr < 0) rr = 0;
            q = rr / 8;
            r = rr % 8;
            if (r == 0) begin
                wc = q;
            end else if (m_dic + r <= 3) begin
                wc = q;
                m_dic = m_dic + r;
            end else begin
                wc = q + 1;
                m_dic = (m_dic + r - 8 > 0) ? m_dic + r - 8 : 0;
            end
            m_ipg = wc;
            m_in_frame = 1'b0;
        end
        return w;
    endfunction

    task automatic cycle(input bit pr, input bit v, input logic [63:0] d, input logic [7:0] kp,
                         input bit l, input bit e, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        bus.pcs_ready_i = pr;
        bus.valid_i     = v;
        bus.data_i      = d;
        bus.keep_i      = kp;
        bus.last_i      = l;
        bus.err_i       = e;
        exp_rdy = pr && (m_ipg == 0);
        acc = exp_rdy && v;
        #1;
        chk_bit("ready_o", bus.ready_o, exp_rdy);
        if (pr) exp_q.push_back(model_step(v, d, kp, l, e));
    endtask

    task automatic idle_cycles(input int n, input int stall_pct);
        bit acc;
        repeat (n) cycle(($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic stall_cycles(input int n, input bit v);
        bit acc;
        repeat (n) cycle(1'b0, v, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, acc);
    endtask

    task automatic underrun_cycles(input int n);
        bit acc;
        repeat (n) cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic offer(input logic [63:0] d, input logic [7:0] kp, input bit l, input bit e,
                         input int stall_pct);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            cycle(($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1, 1'b1, d, kp, l, e, acc);
            tries++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL offer_timeout @%0t: beat not accepted after %0d cycles, expected acceptance", $time, tries);
        end
    endtask

    task automatic send_frame(input int nb, input logic [7:0] lk, input bit ferr,
                              input int gap_pct, input int stall_pct);
        for (int b = 0; b < nb; b++) begin
            bit is_last;
            is_last = (b == nb - 1);
            if (b > 0 && $urandom_range(0, 99) < gap_pct) underrun_cycles($urandom_range(1, 2));
            offer({$urandom, $urandom}, is_last ? lk : 8'($urandom), is_last,
                  is_last ? ferr : (b > 0 && $urandom_range(0, 7) == 0), stall_pct);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bus.pcs_ready_i = 1'b1;
        bus.valid_i = 1'b0;
        bus.last_i = 1'b0;
        bus.err_i = 1'b0;
        exp_q.delete();
        m_in_frame = 1'b0;
        m_ipg = 0;
        m_dic = 0;
        #1;
        chk_word("reset_out", get_out(), IDLE_W);
        chk_bit("reset_ready", bus.ready_o, 1'b1);
        repeat (n) @(negedge clk);
        reset = 1'b0;
        bus.pcs_ready_i = 1'b0;
    endtask

    // Monitor: a word is due after every edge where the PCS accepted; otherwise outputs hold.
    initial begin
        bit fire;
        w_t e;
        forever begin
            @(posedge clk);
            fire = bus.pcs_ready_i && !reset;
            #1;
            if (reset) begin
                hold_ref = IDLE_W;
            end else if (fire) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL word_unexpected @%0t: DUT emitted a word, scoreboard empty", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk_word("word", get_out(), e);
                    hold_ref = e;
                    hold_ref.und = 1'b0;
                end
            end else begin
                chk_word("hold", get_out(), hold_ref);
            end
        end
    end

    initial begin
        #1ms;
        fails++;
        $display("FAIL watchdog @%0t: stimulus did not complete", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i = '0;
        bus.keep_i = '0;
        bus.last_i = 1'b0;
        bus.err_i = 1'b0;
        bus.pcs_ready_i = 1'b1;
        do_reset(2);
        idle_cycles(3, 0);

        // 3-beat frame, full last word, then a waiting frame
        send_frame(3, 8'hFF, 1'b0, 0, 0);
        send_frame(2, 8'hFF, 1'b0, 0, 0);
        idle_cycles(4, 0);

        // back-to-back k=7 frames exercise the deficit counter
        send_frame(2, 8'h7F, 1'b0, 0, 0);
        send_frame(2, 8'h7F, 1'b0, 0, 0);
        send_frame(2, 8'h7F, 1'b0, 0, 0);
        idle_cycles(4, 0);

        // k=1 last beat, single-beat frame, keep=0 terminate
        send_frame(2, 8'h01, 1'b0, 0, 0);
        send_frame(1, 8'h0F, 1'b0, 0, 0);
        send_frame(1, 8'h00, 1'b0, 0, 0);
        idle_cycles(3, 0);

        // two-cycle mid-frame underrun
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        underrun_cycles(2);
        offer({$urandom, $urandom}, 8'h3F, 1'b1, 1'b0, 0);
        idle_cycles(4, 0);

        // PCS pause inside DATA and inside IPG
        do_reset(1);
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        stall_cycles(3, 1'b1);
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        offer({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 0);
        underrun_cycles(0);
        idle_cycles(1, 0);
        stall_cycles(3, 1'b0);
        idle_cycles(3, 0);

        // reset while two IPG idles are still owed
        do_reset(1);
        send_frame(3, 8'hFF, 1'b0, 0, 0);
        do_reset(1);
        send_frame(2, 8'h7F, 1'b0, 0, 0);
        send_frame(2, 8'h7F, 1'b0, 0, 0);
        idle_cycles(3, 0);

        // reset mid-frame
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        offer({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 0);
        do_reset(2);
        send_frame(2, 8'h07, 1'b1, 0, 0);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            int nb, kk;
            logic [7:0] lk;
            nb = $urandom_range(1, 6);
            kk = $urandom_range(0, 8);
            lk = (kk == 0) ? 8'h00 : 8'(8'hFF >> (8 - kk));
            send_frame(nb, lk, ($urandom_range(0, 7) == 0), 12, 15);
            idle_cycles($urandom_range(0, 3), 15);
        end

        idle_cycles(8, 0);
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
